// File: rtl/nibble_deserializer_pkg.sv
// Shared constants for the nibble deserializer: FSM encoding, default sizes
// and the bit-counter width helper.
package nibble_deserializer_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  // Bits needed to count 0..w-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/nibble_deserializer_if.sv
// Valid/ready output bus carrying completed nibbles to the consumer.
interface nibble_deserializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/nibble_deserializer_fifo.sv
// Small FIFO of completed words. Head is read straight from registered
// storage; pointers carry one extra wrap bit to separate full from empty.
module nibble_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW:0]                 wr_q, rd_q;
  logic                        do_push, do_pop;

  // Status flags and qualified push/pop; a pop frees a slot for a push
  // arriving in the same cycle.
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    head_o  = mem_q[rd_q[AW-1:0]];
  end

  // Storage and pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// Re-assembles the MSB-first serial frames from the upstream shifter into
// parallel words, buffers them in a FIFO and flags dropped words.
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic bit_valid,
  input  logic frame_start,
  input  logic abort,
  input  logic ovr_clr,
  output logic overrun,
  output logic busy,
  nibble_deserializer_if.master out_if
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Only the last WIDTH-1 bits are kept; the final bit joins them on push.
  logic [WIDTH-2:0]   asm_q, asm_d;
  logic [WIDTH-1:0]   asm_shift;
  logic               word_done;
  logic               ovr_q, ovr_d;
  logic               fifo_full, fifo_empty, pop, drop;
  logic [WIDTH-1:0]   fifo_head;

  // Framing state, bit counter, assembly register and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      cnt_q   <= '0;
      asm_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next state: abort beats everything, frame_start with a bit (re)starts a
  // frame from either state, plain bits only count while receiving.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    word_done = 1'b0;
    asm_shift = {asm_q, serial_in};
    if (abort) begin
      state_d = ST_HUNT;
      cnt_d   = '0;
    end else if (bit_valid) begin
      if (frame_start) begin
        asm_d   = asm_shift[WIDTH-2:0];
        cnt_d   = CNT_ONE;
        state_d = ST_RECV;
      end else if (state_q == ST_RECV) begin
        asm_d = asm_shift[WIDTH-2:0];
        if (cnt_q == CNT_LAST) begin
          word_done = 1'b1;
          cnt_d     = '0;
          state_d   = ST_HUNT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // Outputs: busy from state, handshake pop, sticky overrun (drop wins
  // over clear).
  always_comb begin
    busy    = (state_q == ST_RECV);
    pop     = !fifo_empty && out_if.out_ready;
    drop    = word_done && fifo_full && !pop;
    ovr_d   = ovr_q;
    if (drop)         ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;
    overrun = ovr_q;
  end

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_head;

  nibble_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (word_done),
    .data_i  (asm_shift),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
